frame_sink: RTL and testbench

FRAME_SINK -- requirements
Module: frame_sink

---
 rtl/pr3_pkg.sv | 44 ++++
 rtl/frame_ram.sv | 44 ++++
 rtl/frame_sink.sv | 193 +++++++++++++++++++
 tb/tb_frame_sink.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pr3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pr3_pkg
// Purpose  : Shared widths, beat record, error bit indices and write-FSM states
// Revision : 1.0 - initial release
// ============================================================================
package pr3_pkg;

    localparam int c_freq_w  = 24;
    localparam int c_phase_w = 16;
    localparam int c_rec_w   = c_freq_w + 2 * c_phase_w;

    localparam int c_err_orphan    = 0;
    localparam int c_err_early_sop = 1;
    localparam int c_err_length    = 2;
    localparam int c_err_overflow  = 3;
    localparam int c_err_w         = 4;

    typedef struct packed {
        logic [c_freq_w-1:0]  freq;
        logic [c_phase_w-1:0] phase_a;
        logic [c_phase_w-1:0] phase_b;
    } result_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } wr_state_e;

    function automatic result_t make_result(
        input logic [c_freq_w-1:0]  freq,
        input logic [c_phase_w-1:0] phase_a,
        input logic [c_phase_w-1:0] phase_b
    );
        result_t r;
        r.freq    = freq;
        r.phase_a = phase_a;
        r.phase_b = phase_b;
        return r;
    endfunction

endpackage : pr3_pkg
`default_nettype wire

// File: rtl/frame_ram.sv
`default_nettype none
// ============================================================================
// Module   : frame_ram
// Purpose  : Simple dual-port record store with registered, reset-cleared read
// Revision : 1.0 - initial release
// ============================================================================
module frame_ram
    import pr3_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  result_t           i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output result_t           o_rd_data
);

    result_t r_mem [DEPTH];
    result_t r_rd_data_q;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register is cleared so outputs are never undefined after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data_q <= '0;
        end else if (i_rd_en) begin
            r_rd_data_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data_q;

endmodule : frame_ram
`default_nettype wire

// File: rtl/frame_sink.sv
`default_nettype none
// ============================================================================
// Module   : frame_sink
// Purpose  : Ping-pong frame capture with length/sequence checking and
//            random-access readout of the oldest complete frame
// Revision : 1.0 - initial release
// ============================================================================
module frame_sink
    import pr3_pkg::*;
#(
    parameter int LENGTH = 2048,
    parameter int AWIDTH = $clog2(LENGTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sink_valid,
    input  logic                 sink_sop,
    input  logic                 sink_eop,
    input  logic [c_freq_w-1:0]  sink_freq,
    input  logic [c_phase_w-1:0] sink_phaseA,
    input  logic [c_phase_w-1:0] sink_phaseB,
    output logic                 source_ready,
    input  logic [AWIDTH-1:0]    read_addr,
    input  logic                 read_release,
    output logic [c_freq_w-1:0]  read_freq,
    output logic [c_phase_w-1:0] read_phaseA,
    output logic [c_phase_w-1:0] read_phaseB,
    output logic [15:0]          frame_cnt,
    output logic [c_err_w-1:0]   error,
    input  logic                 error_clear
);

    localparam logic [AWIDTH-1:0] c_last_addr = AWIDTH'(LENGTH - 1);

    wr_state_e          r_state_q,        w_state_d;
    logic [AWIDTH-1:0]  r_addr_q,         w_addr_d;
    logic               r_wr_bank_q,      w_wr_bank_d;
    logic               r_rd_bank_q,      w_rd_bank_d;
    logic [1:0]         r_full_q,         w_full_d;
    logic               r_source_ready_q, w_source_ready_d;
    logic [15:0]        r_frame_cnt_q,    w_frame_cnt_d;
    logic [c_err_w-1:0] r_error_q,        w_error_d;

    logic               w_err_set_valid;
    logic [c_err_w-1:0] w_err_set;
    logic               w_we;
    logic [AWIDTH-1:0]  w_wr_addr;
    logic               w_complete;
    logic               w_release;
    result_t            w_wr_data;
    result_t            w_rd_data;

    assign w_wr_data = make_result(sink_freq, sink_phaseA, sink_phaseB);
    assign w_release = read_release & r_source_ready_q;

    // Write-side frame parser
    always_comb begin
        w_state_d       = r_state_q;
        w_addr_d        = r_addr_q;
        w_err_set       = '0;
        w_err_set_valid = 1'b0;
        w_we            = 1'b0;
        w_wr_addr       = '0;
        w_complete      = 1'b0;

        if (sink_valid) begin
            if (sink_sop) begin
                if (r_state_q == ST_RECV) begin
                    w_err_set[c_err_early_sop] = 1'b1;
                end
                if (r_full_q[r_wr_bank_q]) begin
                    w_err_set[c_err_overflow] = 1'b1;
                    w_addr_d  = '0;
                    w_state_d = sink_eop ? ST_IDLE : ST_DROP;
                end else begin
                    w_we      = 1'b1;
                    w_wr_addr = '0;
                    if (sink_eop) begin
                        w_addr_d  = '0;
                        w_state_d = ST_IDLE;
                        if (LENGTH == 1) begin
                            w_complete = 1'b1;
                        end else begin
                            w_err_set[c_err_length] = 1'b1;
                        end
                    end else begin
                        w_addr_d  = AWIDTH'(1);
                        w_state_d = ST_RECV;
                    end
                end
            end else begin
                case (r_state_q)
                    ST_IDLE: begin
                        w_err_set[c_err_orphan] = 1'b1;
                    end
                    ST_DROP: begin
                        if (sink_eop) begin
                            w_state_d = ST_IDLE;
                        end
                    end
                    ST_RECV: begin
                        w_we      = 1'b1;
                        w_wr_addr = r_addr_q;
                        if (r_addr_q == c_last_addr) begin
                            w_addr_d  = '0;
                            w_state_d = ST_IDLE;
                            if (sink_eop) begin
                                w_complete = 1'b1;
                            end else begin
                                w_err_set[c_err_length] = 1'b1;
                            end
                        end else if (sink_eop) begin
                            w_err_set[c_err_length] = 1'b1;
                            w_addr_d  = '0;
                            w_state_d = ST_IDLE;
                        end else begin
                            w_addr_d = r_addr_q + AWIDTH'(1);
                        end
                    end
                    default: begin
                        w_addr_d  = '0;
                        w_state_d = ST_IDLE;
                    end
                endcase
            end
        end
        w_err_set_valid = |w_err_set;
    end

    // Bank bookkeeping; completion and release always target different banks
    always_comb begin
        w_full_d = r_full_q;
        if (w_release) begin
            w_full_d[r_rd_bank_q] = 1'b0;
        end
        if (w_complete) begin
            w_full_d[r_wr_bank_q] = 1'b1;
        end
        w_wr_bank_d      = r_wr_bank_q ^ w_complete;
        w_rd_bank_d      = r_rd_bank_q ^ w_release;
        w_frame_cnt_d    = r_frame_cnt_q + 16'(w_complete);
        w_source_ready_d = ~w_release & w_full_d[r_rd_bank_q];
        w_error_d        = r_error_q & ~{c_err_w{error_clear}};
        if (w_err_set_valid) begin
            w_error_d = w_error_d | w_err_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q        <= ST_IDLE;
            r_addr_q         <= '0;
            r_wr_bank_q      <= 1'b0;
            r_rd_bank_q      <= 1'b0;
            r_full_q         <= 2'b00;
            r_source_ready_q <= 1'b0;
            r_frame_cnt_q    <= '0;
            r_error_q        <= '0;
        end else begin
            r_state_q        <= w_state_d;
            r_addr_q         <= w_addr_d;
            r_wr_bank_q      <= w_wr_bank_d;
            r_rd_bank_q      <= w_rd_bank_d;
            r_full_q         <= w_full_d;
            r_source_ready_q <= w_source_ready_d;
            r_frame_cnt_q    <= w_frame_cnt_d;
            r_error_q        <= w_error_d;
        end
    end

    frame_ram #(
        .DEPTH  (2 * LENGTH),
        .ADDR_W (AWIDTH + 1)
    ) u_frame_ram (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_we),
        .i_wr_addr ({r_wr_bank_q, w_wr_addr}),
        .i_wr_data (w_wr_data),
        .i_rd_en   (r_full_q[r_rd_bank_q]),
        .i_rd_addr ({r_rd_bank_q, read_addr}),
        .o_rd_data (w_rd_data)
    );

    assign source_ready = r_source_ready_q;
    assign read_freq    = w_rd_data.freq;
    assign read_phaseA  = w_rd_data.phase_a;
    assign read_phaseB  = w_rd_data.phase_b;
    assign frame_cnt    = r_frame_cnt_q;
    assign error        = r_error_q;

endmodule : frame_sink
`default_nettype wire

// File: tb/tb_frame_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_sink
// Purpose  : Directed and randomized checking of frame_sink against a
//            frame-queue reference model (LENGTH = 4)
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_sink;

    localparam int L  = 4;
    localparam int AW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        sink_valid, sink_sop, sink_eop;
    logic [23:0] sink_freq;
    logic [15:0] sink_phaseA, sink_phaseB;
    logic        source_ready;
    logic [AW-1:0] read_addr;
    logic        read_release;
    logic [23:0] read_freq;
    logic [15:0] read_phaseA, read_phaseB;
    logic [15:0] frame_cnt;
    logic [3:0]  error;
    logic        error_clear;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    frame_sink #(.LENGTH(L), .AWIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_freq    (sink_freq),
        .sink_phaseA  (sink_phaseA),
        .sink_phaseB  (sink_phaseB),
        .source_ready (source_ready),
        .read_addr    (read_addr),
        .read_release (read_release),
        .read_freq    (read_freq),
        .read_phaseA  (read_phaseA),
        .read_phaseB  (read_phaseB),
        .frame_cnt    (frame_cnt),
        .error        (error),
        .error_clear  (error_clear)
    );

    always #5 clk = ~clk;

    // Reference model: completed frames form a FIFO of depth two
    typedef logic [L-1:0][55:0] frame_t;
    frame_t      fifo[$];
    frame_t      part;
    int          pcnt  = 0;
    int          mode  = 0;   // 0 idle, 1 receiving, 2 dropping
    logic        m_ready = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [3:0]  m_err = '0;
    logic [55:0] m_rd  = '0;

    always @(posedge clk) begin
        logic [3:0]  set;
        logic        done, rel;
        logic [55:0] rec;
        if (reset) begin
            fifo.delete();
            part = '0; pcnt = 0; mode = 0;
            m_ready = 1'b0; m_cnt = '0; m_err = '0; m_rd = '0;
        end else begin
            set = '0; done = 1'b0;
            if (fifo.size() > 0) m_rd = fifo[0][read_addr];
            rel = read_release && m_ready;
            if (sink_valid) begin
                rec = {sink_freq, sink_phaseA, sink_phaseB};
                if (sink_sop) begin
                    if (mode == 1) set[1] = 1'b1;
                    if (fifo.size() == 2) begin
                        set[3] = 1'b1;
                        mode = sink_eop ? 0 : 2;
                    end else begin
                        part = '0; part[0] = rec; pcnt = 1;
                        if (sink_eop) begin set[2] = 1'b1; mode = 0; end
                        else mode = 1;
                    end
                end else if (mode == 0) begin
                    set[0] = 1'b1;
                end else if (mode == 2) begin
                    if (sink_eop) mode = 0;
                end else begin
                    part[pcnt] = rec; pcnt++;
                    if (sink_eop) begin
                        if (pcnt == L) done = 1'b1; else set[2] = 1'b1;
                        mode = 0;
                    end else if (pcnt == L) begin
                        set[2] = 1'b1; mode = 0;
                    end
                end
            end
            if (rel) void'(fifo.pop_front());
            if (done) begin fifo.push_back(part); m_cnt++; end
            m_err   = (error_clear ? 4'b0 : m_err) | set;
            m_ready = rel ? 1'b0 : (fifo.size() > 0);
        end
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("source_ready", 64'(source_ready), 64'(m_ready));
            cmp("frame_cnt",    64'(frame_cnt),    64'(m_cnt));
            cmp("error",        64'(error),        64'(m_err));
            cmp("read_data",    64'({read_freq, read_phaseA, read_phaseB}), 64'(m_rd));
        end
    end

    task automatic beat(input logic v, input logic s, input logic e, input logic [23:0] f);
        sink_valid  = v;
        sink_sop    = s;
        sink_eop    = e;
        sink_freq   = f;
        sink_phaseA = f[15:0] ^ 16'h5a5a;
        sink_phaseB = f[15:0] ^ 16'hc3c3;
        @(posedge clk);
        #1;
        sink_valid   = 1'b0;
        sink_sop     = 1'b0;
        sink_eop     = 1'b0;
        read_release = 1'b0;
        error_clear  = 1'b0;
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 1'b0, 24'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] base);
        for (int i = 0; i < L; i++)
            beat(1'b1, i == 0, i == L - 1, base + 24'(i));
    endtask

    initial begin
        int gen_pos;
        logic v, s, e;
        reset = 1'b1; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        sink_freq = '0; sink_phaseA = '0; sink_phaseB = '0;
        read_addr = '0; read_release = 1'b0; error_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk_en = 1'b1;

        // Reset state
        cmp("rst_ready", 64'(source_ready), 64'd0);
        cmp("rst_cnt",   64'(frame_cnt),    64'd0);
        cmp("rst_error", 64'(error),        64'd0);
        cmp("rst_rdata", 64'(read_freq),    64'd0);

        // Good frame, freq 1..4
        send_frame(24'd1);
        cmp("good_ready", 64'(source_ready), 64'd1);
        cmp("good_cnt",   64'(frame_cnt),    64'd1);
        read_addr = 2'd2;
        idle();
        cmp("good_rd_freq",   64'(read_freq),   64'd3);
        cmp("good_rd_phaseA", 64'(read_phaseA), 64'h5a59);

        // Short frame of three beats
        do_reset();
        beat(1'b1, 1'b1, 1'b0, 24'd5);
        beat(1'b1, 1'b0, 1'b0, 24'd6);
        beat(1'b1, 1'b0, 1'b1, 24'd7);
        cmp("short_error", 64'(error),        64'h4);
        cmp("short_ready", 64'(source_ready), 64'd0);
        cmp("short_cnt",   64'(frame_cnt),    64'd0);

        // Three frames without release: third overflows
        do_reset();
        send_frame(24'd10);
        send_frame(24'd20);
        send_frame(24'd30);
        cmp("ovf_cnt",   64'(frame_cnt), 64'd2);
        cmp("ovf_error", 64'(error),     64'h8);
        read_addr = 2'd0;
        idle();
        cmp("ovf_rd_first", 64'(read_freq), 64'd10);
        read_release = 1'b1;
        idle();
        cmp("rel_ready_drop", 64'(source_ready), 64'd0);
        idle();
        cmp("rel_ready_rise", 64'(source_ready), 64'd1);
        cmp("rel_rd_second",  64'(read_freq),    64'd20);

        // Early sop restarts the frame
        do_reset();
        beat(1'b1, 1'b1, 1'b0, 24'd50);
        send_frame(24'd60);
        cmp("early_error", 64'(error),     64'h2);
        cmp("early_cnt",   64'(frame_cnt), 64'd1);
        read_addr = 2'd3;
        idle();
        cmp("early_rd", 64'(read_freq), 64'd63);

        // Orphan beats, then clear
        do_reset();
        beat(1'b1, 1'b0, 1'b0, 24'd7);
        beat(1'b1, 1'b0, 1'b0, 24'd8);
        cmp("orphan_error", 64'(error),     64'h1);
        cmp("orphan_cnt",   64'(frame_cnt), 64'd0);
        error_clear = 1'b1;
        idle();
        cmp("orphan_clear", 64'(error), 64'h0);

        // Reset mid-frame discards stored and partial frames
        do_reset();
        send_frame(24'd40);
        beat(1'b1, 1'b1, 1'b0, 24'd44);
        beat(1'b1, 1'b0, 1'b0, 24'd45);
        reset = 1'b1;
        beat(1'b1, 1'b0, 1'b0, 24'd46);
        reset = 1'b0;
        cmp("midrst_ready", 64'(source_ready), 64'd0);
        cmp("midrst_cnt",   64'(frame_cnt),    64'd0);
        cmp("midrst_rdata", 64'(read_freq),    64'd0);
        send_frame(24'd70);
        read_addr = 2'd1;
        idle();
        cmp("midrst_new_cnt", 64'(frame_cnt), 64'd1);
        cmp("midrst_new_rd",  64'(read_freq), 64'd71);

        // Randomized traffic
        gen_pos = 0;
        for (int n = 0; n < 4000; n++) begin
            v = ($urandom_range(0, 99) < 70);
            s = (gen_pos == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
            e = (gen_pos == L - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 14) == 0);
            read_addr    = AW'($urandom_range(0, L - 1));
            read_release = ($urandom_range(0, 5) == 0);
            error_clear  = ($urandom_range(0, 30) == 0);
            reset        = ($urandom_range(0, 500) == 0);
            if (v) begin
                gen_pos = s ? 1 : gen_pos + 1;
                if (e || gen_pos >= L) gen_pos = 0;
            end
            beat(v, s, e, 24'($urandom));
            reset = 1'b0;
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_frame_sink
`default_nettype wire
